// File: rtl/vx_alu_exec_pkg.sv
// Shared definitions for the ALU execute block: machine sizes, ALU op
// encodings and the payload layouts of the two pipeline stages.
package vx_alu_exec_pkg;

  localparam int NUM_THREADS   = 4;
  localparam int UUID_BITS     = 44;
  localparam int NW_BITS       = 2;
  localparam int NR_BITS       = 5;
  localparam int NT_BITS       = 2;
  localparam int INST_ALU_BITS = 4;
  localparam int INST_MOD_BITS = 3;

  typedef enum logic [INST_ALU_BITS-1:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_LUI   = 4'd2,
    ALU_AUIPC = 4'd3,
    ALU_SLT   = 4'd4,
    ALU_SLTU  = 4'd5,
    ALU_SLL   = 4'd6,
    ALU_SRL   = 4'd7,
    ALU_SRA   = 4'd8,
    ALU_XOR   = 4'd9,
    ALU_OR    = 4'd10,
    ALU_AND   = 4'd11
  } alu_op_e;

  // Operands and control captured at acceptance.
  typedef struct packed {
    logic [UUID_BITS-1:0]              uuid;
    logic [NW_BITS-1:0]                wid;
    logic [NUM_THREADS-1:0]            tmask;
    logic [31:0]                       pc;
    logic [INST_ALU_BITS-1:0]          op_type;
    logic [INST_MOD_BITS-1:0]          op_mod;
    logic                              use_pc;
    logic                              use_imm;
    logic [31:0]                       imm;
    logic [NUM_THREADS-1:0][31:0]      rs1_data;
    logic [NUM_THREADS-1:0][31:0]      rs2_data;
    logic [NR_BITS-1:0]                rd;
    logic                              wb;
  } s0_t;

  // Per-thread result plus the tags that travel with it to writeback.
  typedef struct packed {
    logic [UUID_BITS-1:0]              uuid;
    logic [NW_BITS-1:0]                wid;
    logic [NUM_THREADS-1:0]            tmask;
    logic [31:0]                       pc;
    logic [NUM_THREADS-1:0][31:0]      data;
    logic [NR_BITS-1:0]                rd;
    logic                              wb;
  } s1_t;

  // Only the base modifier selects a real ALU operation.
  function automatic logic mod_is_base(input logic [INST_MOD_BITS-1:0] op_mod);
    return (op_mod == {INST_MOD_BITS{1'b0}});
  endfunction

endpackage

// File: rtl/vx_alu_exec_lane.sv
// Single-thread 32-bit integer ALU. Pure combinational; all arithmetic
// wraps modulo 2^32 and no flags are produced.
module vx_alu_exec_lane
  import vx_alu_exec_pkg::*;
(
  input  logic [31:0]              a,
  input  logic [31:0]              b,
  input  logic [INST_ALU_BITS-1:0] op_type,
  output logic [31:0]              result
);

  logic [4:0] shamt;
  assign shamt = b[4:0];

  // Select the operation; unknown encodings yield zero.
  always_comb begin
    result = 32'd0;
    case (op_type)
      ALU_ADD,
      ALU_AUIPC: result = a + b;
      ALU_SUB:   result = a - b;
      ALU_LUI:   result = b;
      ALU_SLT:   result = {31'd0, ($signed(a) < $signed(b))};
      ALU_SLTU:  result = {31'd0, (a < b)};
      ALU_SLL:   result = a << shamt;
      ALU_SRL:   result = a >> shamt;
      ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
      ALU_XOR:   result = a ^ b;
      ALU_OR:    result = a | b;
      ALU_AND:   result = a & b;
      default:   result = 32'd0;
    endcase
  end

endmodule

// File: rtl/vx_alu_exec_pipe_reg.sv
// Elastic pipeline register: a valid bit cleared by reset and a payload
// that is loaded (together with valid) whenever enable is high.
module vx_alu_exec_pipe_reg #(
  parameter int DATAW = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             valid_in,
  input  logic [DATAW-1:0] data_in,
  output logic             valid_out,
  output logic [DATAW-1:0] data_out
);

  // Valid bit: dropped on reset, otherwise follows the upstream valid when the stage moves.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out <= 1'b0;
    end else if (enable) begin
      valid_out <= valid_in;
    end
  end

  // Payload: captured with the valid bit; contents are don't-care while invalid.
  always_ff @(posedge clk) begin
    if (enable) begin
      data_out <= data_in;
    end
  end

endmodule

// File: rtl/vx_alu_exec.sv
// ALU execute unit: two-stage elastic pipeline. S0 holds operands and
// control, S1 holds the per-thread results that drive the commit port.
module vx_alu_exec
  import vx_alu_exec_pkg::*;
#(
  parameter int CORE_ID = 0
) (
  input  logic                          clk,
  input  logic                          reset,

  input  logic                          alu_req_valid,
  input  logic [UUID_BITS-1:0]          alu_req_uuid,
  input  logic [NW_BITS-1:0]            alu_req_wid,
  input  logic [NUM_THREADS-1:0]        alu_req_tmask,
  input  logic [31:0]                   alu_req_pc,
  input  logic [31:0]                   alu_req_next_pc,
  input  logic [INST_ALU_BITS-1:0]      alu_req_op_type,
  input  logic [INST_MOD_BITS-1:0]      alu_req_op_mod,
  input  logic                          alu_req_use_pc,
  input  logic                          alu_req_use_imm,
  input  logic [31:0]                   alu_req_imm,
  input  logic [NT_BITS-1:0]            alu_req_tid,
  input  logic [NUM_THREADS-1:0][31:0]  alu_req_rs1_data,
  input  logic [NUM_THREADS-1:0][31:0]  alu_req_rs2_data,
  input  logic [NR_BITS-1:0]            alu_req_rd,
  input  logic                          alu_req_wb,
  input  logic [2:0]                    alu_req_func3,
  input  logic [6:0]                    alu_req_func7,
  output logic                          alu_req_ready,

  output logic                          alu_commit_valid,
  output logic [UUID_BITS-1:0]          alu_commit_uuid,
  output logic [NW_BITS-1:0]            alu_commit_wid,
  output logic [NUM_THREADS-1:0]        alu_commit_tmask,
  output logic [31:0]                   alu_commit_pc,
  output logic [NUM_THREADS-1:0][31:0]  alu_commit_data,
  output logic [NR_BITS-1:0]            alu_commit_rd,
  output logic                          alu_commit_wb,
  output logic                          alu_commit_eop,
  input  logic                          alu_commit_ready,

  output logic [31:0]                   perf_stalls
);

  s0_t s0_in;
  s0_t s0_q;
  s1_t s1_in;
  s1_t s1_q;

  logic s0_valid;
  logic s1_valid;
  logic s0_enable;
  logic s1_enable;
  logic s0_base;

  logic [NUM_THREADS-1:0][31:0] lane_a;
  logic [NUM_THREADS-1:0][31:0] lane_b;
  logic [NUM_THREADS-1:0][31:0] lane_res;

  // next_PC, tid, func3/func7 and CORE_ID carry no meaning for plain ALU ops.
  logic unused_inputs;
  assign unused_inputs = ^{alu_req_next_pc, alu_req_tid, alu_req_func3,
                           alu_req_func7, 1'(CORE_ID)};

  // A stage moves when its successor is empty or moving; ready is held low in reset.
  assign s1_enable     = !s1_valid || alu_commit_ready;
  assign s0_enable     = !reset && (!s0_valid || s1_enable);
  assign alu_req_ready = s0_enable;

  // Pack the incoming request into the S0 payload.
  always_comb begin
    s0_in          = '0;
    s0_in.uuid     = alu_req_uuid;
    s0_in.wid      = alu_req_wid;
    s0_in.tmask    = alu_req_tmask;
    s0_in.pc       = alu_req_pc;
    s0_in.op_type  = alu_req_op_type;
    s0_in.op_mod   = alu_req_op_mod;
    s0_in.use_pc   = alu_req_use_pc;
    s0_in.use_imm  = alu_req_use_imm;
    s0_in.imm      = alu_req_imm;
    s0_in.rs1_data = alu_req_rs1_data;
    s0_in.rs2_data = alu_req_rs2_data;
    s0_in.rd       = alu_req_rd;
    s0_in.wb       = alu_req_wb;
  end

  vx_alu_exec_pipe_reg #(.DATAW($bits(s0_t))) u_s0 (
    .clk       (clk),
    .reset     (reset),
    .enable    (s0_enable),
    .valid_in  (alu_req_valid),
    .data_in   (s0_in),
    .valid_out (s0_valid),
    .data_out  (s0_q)
  );

  for (genvar t = 0; t < NUM_THREADS; t++) begin : g_lane
    assign lane_a[t] = s0_q.use_pc  ? s0_q.pc  : s0_q.rs1_data[t];
    assign lane_b[t] = s0_q.use_imm ? s0_q.imm : s0_q.rs2_data[t];

    vx_alu_exec_lane u_lane (
      .a       (lane_a[t]),
      .b       (lane_b[t]),
      .op_type (s0_q.op_type),
      .result  (lane_res[t])
    );
  end

  assign s0_base = mod_is_base(s0_q.op_mod);

  // Build the S1 payload: mask inactive lanes and squash non-base modifiers.
  always_comb begin
    s1_in       = '0;
    s1_in.uuid  = s0_q.uuid;
    s1_in.wid   = s0_q.wid;
    s1_in.tmask = s0_q.tmask;
    s1_in.pc    = s0_q.pc;
    s1_in.rd    = s0_q.rd;
    s1_in.wb    = s0_q.wb && s0_base;
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (s0_q.tmask[t] && s0_base) begin
        s1_in.data[t] = lane_res[t];
      end else begin
        s1_in.data[t] = 32'd0;
      end
    end
  end

  vx_alu_exec_pipe_reg #(.DATAW($bits(s1_t))) u_s1 (
    .clk       (clk),
    .reset     (reset),
    .enable    (s1_enable),
    .valid_in  (s0_valid),
    .data_in   (s1_in),
    .valid_out (s1_valid),
    .data_out  (s1_q)
  );

  assign alu_commit_valid = s1_valid;
  assign alu_commit_uuid  = s1_q.uuid;
  assign alu_commit_wid   = s1_q.wid;
  assign alu_commit_tmask = s1_q.tmask;
  assign alu_commit_pc    = s1_q.pc;
  assign alu_commit_data  = s1_q.data;
  assign alu_commit_rd    = s1_q.rd;
  assign alu_commit_wb    = s1_q.wb;
  assign alu_commit_eop   = 1'b1;

  // Count commit stall cycles, pinned at the maximum value instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stalls <= 32'd0;
    end else if (alu_commit_valid && !alu_commit_ready &&
                 (perf_stalls != 32'hFFFF_FFFF)) begin
      perf_stalls <= perf_stalls + 32'd1;
    end
  end

endmodule
